// File: rtl/mips32_regbank_sb.sv
// Register bank with RAW scoreboard for the pipelined MIPS32 core (ID read, WB write).
// Latency: operands appear on a_out/b_out one clock after an accepted ID instruction.
// Backpressure: combinational stall holds ID while a source is pending or a dest counter is full.
//
// Ports:
//   clk, rst                   clock (rising edge) and asynchronous active-high reset
//   id_valid, id_rs, id_rt     ID-stage instruction and its source registers
//   id_use_rt                  instruction really reads rt
//   id_wr, id_rd               instruction writes a destination, and which one
//   stall                      combinational: ID must hold instruction and PC
//   a_out, b_out, issue        registered operands; issue marks a load on the last edge
//   wb_en, wb_addr, wb_data    write-back port
//   flush                      taken branch: clear every pending counter
//   pend_any                   combinational: some register has a write in flight
//
// Build option: define WB_BYPASS_EN to forward write-back data to a reader in
// the same cycle when that write is the last one pending on the register.
// Without it the reader waits one extra cycle and always reads the register file.

module mips32_regbank_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int PEND_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_use_rt,
  input  logic              id_wr,
  input  logic [ADDR_W-1:0] id_rd,
  output logic              stall,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              issue,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              pend_any
);

  localparam logic [PEND_W-1:0] PEND_MAX  = '1;
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_ZERO = '0;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [PEND_W-1:0] pend [NUM_REGS];

  // Per-port lookups. The loops start at 1 so R0 and any address at or above
  // NUM_REGS decode to "value 0, never pending" without separate range checks.
  logic [PEND_W-1:0] rs_pend, rt_pend, rd_pend, wb_pend;
  logic [DATA_W-1:0] rs_reg, rt_reg;

  always_comb begin
    rs_pend = PEND_ZERO;
    rt_pend = PEND_ZERO;
    rd_pend = PEND_ZERO;
    wb_pend = PEND_ZERO;
    rs_reg  = '0;
    rt_reg  = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (int'(id_rs) == i) begin
        rs_pend = pend[i];
        rs_reg  = regs[i];
      end
      if (int'(id_rt) == i) begin
        rt_pend = pend[i];
        rt_reg  = regs[i];
      end
      if (int'(id_rd) == i) rd_pend = pend[i];
      if (int'(wb_addr) == i) wb_pend = pend[i];
    end
  end

  // The write-back in flight retires the final pending write of its register.
  logic wb_last;
`ifdef WB_BYPASS_EN
  assign wb_last = wb_en && (wb_pend == PEND_ONE);
`else
  assign wb_last = 1'b0;
`endif

  logic byp_rs, byp_rt;
  assign byp_rs = wb_last && (id_rs == wb_addr);
  assign byp_rt = wb_last && (id_rt == wb_addr);

  // A zero pend value already covers R0 and out-of-range sources.
  logic haz_rs, haz_rt, sat_rd;
  assign haz_rs = (rs_pend != PEND_ZERO) && !byp_rs;
  assign haz_rt = (rt_pend != PEND_ZERO) && !byp_rt;
  // A full destination counter would wrap on another issue, so hold ID instead.
  assign sat_rd = id_wr && (rd_pend == PEND_MAX);

  assign stall = id_valid && (haz_rs || (id_use_rt && haz_rt) || sat_rd);

  logic accept;
  assign accept = id_valid && !stall;

  logic [DATA_W-1:0] val_rs, val_rt;
  assign val_rs = byp_rs ? wb_data : rs_reg;
  assign val_rt = byp_rt ? wb_data : rt_reg;

  always_comb begin
    pend_any = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (pend[i] != PEND_ZERO) pend_any = 1'b1;
    end
  end

  // Register file. A stale write-back (after a flush) and a read of the same
  // register on the same edge returns the old contents: no bypass applies then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wb_en && (int'(wb_addr) == i)) regs[i] <= wb_data;
      end
    end
  end

  // Pending-write counters. Increment on an accepted writer, decrement on
  // write-back (clamped at zero so late write-backs after a flush are harmless).
  // Both on the same register cancel. Flush wins over everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) pend[i] <= PEND_ZERO;
    end else if (flush) begin
      for (int i = 0; i < NUM_REGS; i++) pend[i] <= PEND_ZERO;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (accept && id_wr && (int'(id_rd) == i)) begin
          if (!(wb_en && (int'(wb_addr) == i) && (pend[i] != PEND_ZERO)))
            pend[i] <= pend[i] + PEND_ONE;
        end else if (wb_en && (int'(wb_addr) == i) && (pend[i] != PEND_ZERO)) begin
          pend[i] <= pend[i] - PEND_ONE;
        end
      end
    end
  end

  // Operand registers hold their value when nothing is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out <= '0;
      b_out <= '0;
      issue <= 1'b0;
    end else begin
      issue <= accept;
      if (accept) begin
        a_out <= val_rs;
        b_out <= val_rt;
      end
    end
  end

endmodule

// File: tb/tb_mips32_regbank_sb.sv
module tb_mips32_regbank_sb;

  logic        clk, rst;
  logic        id_valid, id_use_rt, id_wr, wb_en, flush;
  logic [4:0]  id_rs, id_rt, id_rd, wb_addr;
  logic [31:0] wb_data;
  logic        stall, issue, pend_any;
  logic [31:0] a_out, b_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain arrays of values and in-flight write counts.
  localparam int PMAX = 3;
  int          m_pend [32];
  logic [31:0] m_reg  [32];
  logic [31:0] m_a, m_b;
  logic        m_issue;

  mips32_regbank_sb dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_use_rt(id_use_rt),
    .id_wr(id_wr), .id_rd(id_rd), .stall(stall),
    .a_out(a_out), .b_out(b_out), .issue(issue),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .pend_any(pend_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input int rs, input int rt, input logic use_rt,
                       input logic wr, input int rd, input logic we, input int wa,
                       input logic [31:0] wd, input logic fl);
    id_valid  = v;
    id_rs     = 5'(rs);
    id_rt     = 5'(rt);
    id_use_rt = use_rt;
    id_wr     = wr;
    id_rd     = 5'(rd);
    wb_en     = we;
    wb_addr   = 5'(wa);
    wb_data   = wd;
    flush     = fl;
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 32'h0, 1'b0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_pend[i] = 0;
      m_reg[i]  = 32'h0;
    end
    m_a = 32'h0;
    m_b = 32'h0;
    m_issue = 1'b0;
  endtask

  function automatic bit m_byp(int r);
`ifdef WB_BYPASS_EN
    return wb_en && (int'(wb_addr) == r) && (r != 0) && (m_pend[r] == 1);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_haz(int r);
    return (r != 0) && (m_pend[r] != 0) && !m_byp(r);
  endfunction

  function automatic bit m_stall();
    return id_valid && (m_haz(int'(id_rs)) || (id_use_rt && m_haz(int'(id_rt))) ||
                        (id_wr && id_rd != 0 && m_pend[id_rd] == PMAX));
  endfunction

  function automatic bit m_pend_any();
    int s = 0;
    for (int i = 0; i < 32; i++) s += m_pend[i];
    return s != 0;
  endfunction

  function automatic logic [31:0] m_val(int r);
    if (r == 0) return 32'h0;
    if (m_byp(r)) return wb_data;
    return m_reg[r];
  endfunction

  // Advance one clock edge and apply the architectural effect of the cycle.
  task automatic tick();
    bit          acc, inc, dec, fl, we;
    int          rd, wa;
    logic [31:0] na, nb, wd;
    acc = id_valid && !m_stall();
    na  = m_val(int'(id_rs));
    nb  = m_val(int'(id_rt));
    rd  = int'(id_rd);
    wa  = int'(wb_addr);
    wd  = wb_data;
    we  = wb_en;
    fl  = flush;
    inc = acc && id_wr && rd != 0;
    dec = we && wa != 0 && m_pend[wa] > 0;
    @(posedge clk);
    m_issue = acc;
    if (acc) begin
      m_a = na;
      m_b = nb;
    end
    if (we && wa != 0) m_reg[wa] = wd;
    if (fl) begin
      for (int i = 0; i < 32; i++) m_pend[i] = 0;
    end else begin
      if (inc) m_pend[rd] = m_pend[rd] + 1;
      if (dec) m_pend[wa] = m_pend[wa] - 1;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 5, 6, 1'b1, 1'b1, 5, 1'b1, 5, 32'hDEAD_BEEF, 1'b0);
    #2;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", stall); end
    n_checks++;
    if (pend_any !== 1'b0) begin n_fail++; $display("FAIL reset_pend_any: got %0b want 0", pend_any); end
    n_checks++;
    if (issue !== 1'b0) begin n_fail++; $display("FAIL reset_issue: got %0b want 0", issue); end
    n_checks++;
    if (a_out !== 32'h0 || b_out !== 32'h0) begin
      n_fail++; $display("FAIL reset_operands: got a=%h b=%h want 0", a_out, b_out);
    end
    n_checks++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    model_reset();
  endtask

  task automatic test_reset_midrun();
    drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1, 9, 32'h55, 1'b0);
    tick();
    repeat (2) begin
      drive(1'b1, 9, 9, 1'b1, 1'b1, 5, 1'b0, 0, 32'h0, 1'b0);
      #1;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL midrun_stall: got %0b want 0", stall); end
      n_checks++;
      tick();
    end
    if (a_out !== 32'h55 || issue !== 1'b1) begin
      n_fail++; $display("FAIL midrun_load: got a=%h issue=%0b want a=55 issue=1", a_out, issue);
    end
    n_checks++;
    idle();
    if (pend_any !== 1'b1) begin n_fail++; $display("FAIL midrun_pend: got %0b want 1", pend_any); end
    n_checks++;
    #3;
    rst = 1'b1;
    #1;
    if (pend_any !== 1'b0 || a_out !== 32'h0 || issue !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_async_reset: got pend_any=%0b a=%h issue=%0b want 0 0 0", pend_any, a_out, issue);
    end
    n_checks++;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_raw();
    drive(1'b1, 0, 0, 1'b0, 1'b1, 2, 1'b0, 0, 32'h0, 1'b0);
    tick();
    drive(1'b1, 2, 0, 1'b0, 1'b0, 0, 1'b0, 0, 32'h0, 1'b0);
    repeat (2) begin
      #1;
      if (stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall_wait: got %0b want 1", stall); end
      n_checks++;
      tick();
    end
    drive(1'b1, 2, 0, 1'b0, 1'b0, 0, 1'b1, 2, 32'd130, 1'b0);
    #1;
`ifdef WB_BYPASS_EN
    if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_wb_cycle: got stall=%0b want 0", stall); end
    n_checks++;
    tick();
`else
    if (stall !== 1'b1) begin n_fail++; $display("FAIL raw_wb_cycle: got stall=%0b want 1", stall); end
    n_checks++;
    tick();
    if (issue !== 1'b0) begin n_fail++; $display("FAIL raw_no_early_issue: got %0b want 0", issue); end
    n_checks++;
    drive(1'b1, 2, 0, 1'b0, 1'b0, 0, 1'b0, 0, 32'h0, 1'b0);
    #1;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_after_wb: got stall=%0b want 0", stall); end
    n_checks++;
    tick();
`endif
    if (issue !== 1'b1 || a_out !== 32'd130) begin
      n_fail++; $display("FAIL raw_issue: got issue=%0b a=%0d want 1 130", issue, a_out);
    end
    n_checks++;
    idle();
    tick();
  endtask

  task automatic test_r0();
    drive(1'b1, 0, 0, 1'b1, 1'b1, 0, 1'b1, 0, 32'hFFFF_FFFF, 1'b0);
    #1;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall: got %0b want 0", stall); end
    n_checks++;
    tick();
    if (a_out !== 32'h0 || b_out !== 32'h0 || issue !== 1'b1) begin
      n_fail++; $display("FAIL r0_read: got a=%h b=%h issue=%0b want 0 0 1", a_out, b_out, issue);
    end
    n_checks++;
    if (pend_any !== 1'b0) begin n_fail++; $display("FAIL r0_pend: got %0b want 0", pend_any); end
    n_checks++;
    idle();
    tick();
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 0, 0, 1'b0, 1'b1, 7, 1'b0, 0, 32'h0, 1'b0);
      #1;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL sat_fill_%0d: got stall=%0b want 0", k, stall); end
      n_checks++;
      tick();
    end
    drive(1'b1, 0, 0, 1'b0, 1'b1, 7, 1'b1, 7, 32'h77, 1'b0);
    #1;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL sat_full: got stall=%0b want 1", stall); end
    n_checks++;
    tick();
    drive(1'b1, 0, 0, 1'b0, 1'b1, 7, 1'b0, 0, 32'h0, 1'b0);
    #1;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL sat_release: got stall=%0b want 0", stall); end
    n_checks++;
    tick();
    if (issue !== 1'b1) begin n_fail++; $display("FAIL sat_issue: got %0b want 1", issue); end
    n_checks++;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1, 7, 32'h70 + 32'(k), 1'b0);
      tick();
    end
    idle();
    #1;
    if (pend_any !== 1'b0) begin n_fail++; $display("FAIL sat_drain: got pend_any=%0b want 0", pend_any); end
    n_checks++;
  endtask

  task automatic test_flush();
    drive(1'b1, 0, 0, 1'b0, 1'b1, 3, 1'b0, 0, 32'h0, 1'b0);
    tick();
    drive(1'b1, 0, 0, 1'b0, 1'b1, 4, 1'b0, 0, 32'h0, 1'b0);
    tick();
    tick();
    drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 32'h0, 1'b1);
    #1;
    if (pend_any !== 1'b1) begin n_fail++; $display("FAIL flush_before: got pend_any=%0b want 1", pend_any); end
    n_checks++;
    tick();
    if (pend_any !== 1'b0) begin n_fail++; $display("FAIL flush_after: got pend_any=%0b want 0", pend_any); end
    n_checks++;
    drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1, 3, 32'd9, 1'b0);
    tick();
    if (pend_any !== 1'b0) begin n_fail++; $display("FAIL flush_late_wb: got pend_any=%0b want 0", pend_any); end
    n_checks++;
    // Stale write-back on the same edge as a read: old value comes out.
    drive(1'b1, 3, 0, 1'b0, 1'b0, 0, 1'b1, 3, 32'd10, 1'b0);
    #1;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_read_stall: got %0b want 0", stall); end
    n_checks++;
    tick();
    if (a_out !== 32'd9) begin n_fail++; $display("FAIL flush_reg3: got a=%0d want 9", a_out); end
    n_checks++;
    drive(1'b1, 3, 0, 1'b0, 1'b0, 0, 1'b0, 0, 32'h0, 1'b0);
    tick();
    if (a_out !== 32'd10) begin n_fail++; $display("FAIL stale_wb_visible: got a=%0d want 10", a_out); end
    n_checks++;
    idle();
    tick();
  endtask

  task automatic test_inc_dec();
    drive(1'b1, 0, 0, 1'b0, 1'b1, 6, 1'b0, 0, 32'h0, 1'b0);
    tick();
    drive(1'b1, 0, 0, 1'b0, 1'b1, 6, 1'b1, 6, 32'h66, 1'b0);
    #1;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL incdec_accept: got stall=%0b want 0", stall); end
    n_checks++;
    tick();
    drive(1'b1, 6, 0, 1'b0, 1'b0, 0, 1'b0, 0, 32'h0, 1'b0);
    #1;
    if (pend_any !== 1'b1 || stall !== 1'b1) begin
      n_fail++; $display("FAIL incdec_still_pending: got pend_any=%0b stall=%0b want 1 1", pend_any, stall);
    end
    n_checks++;
    tick();
    drive(1'b1, 6, 0, 1'b0, 1'b0, 0, 1'b1, 6, 32'h67, 1'b0);
    #1;
    if (stall !== m_stall()) begin n_fail++; $display("FAIL incdec_wb_stall: got %0b want %0b", stall, m_stall()); end
    n_checks++;
    tick();
    idle();
    tick();
  endtask

  task automatic test_random();
    int rs, rt, rd, wa;
    for (int c = 0; c < 400; c++) begin
      rs = int'($urandom_range(0, 7));
      rt = int'($urandom_range(0, 7));
      rd = int'($urandom_range(0, 7));
      wa = int'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 7; i >= 1; i--) if (m_pend[i] != 0) wa = i;
      end
      drive($urandom_range(0, 9) < 7, rs, rt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd,
            $urandom_range(0, 1) == 1, wa, $urandom, $urandom_range(0, 19) == 0);
      #1;
      if (stall !== m_stall()) begin
        n_fail++; $display("FAIL rand_stall c=%0d: got %0b want %0b", c, stall, m_stall());
      end
      n_checks++;
      if (pend_any !== m_pend_any()) begin
        n_fail++; $display("FAIL rand_pend_any c=%0d: got %0b want %0b", c, pend_any, m_pend_any());
      end
      n_checks++;
      tick();
      if (issue !== m_issue) begin n_fail++; $display("FAIL rand_issue c=%0d: got %0b want %0b", c, issue, m_issue); end
      n_checks++;
      if (a_out !== m_a) begin n_fail++; $display("FAIL rand_a c=%0d: got %h want %h", c, a_out, m_a); end
      n_checks++;
      if (b_out !== m_b) begin n_fail++; $display("FAIL rand_b c=%0d: got %h want %h", c, b_out, m_b); end
      n_checks++;
    end
    idle();
    tick();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    model_reset();
    #1;
    rst = 1'b1;
    test_reset();
    test_reset_midrun();
    test_raw();
    test_r0();
    test_saturation();
    test_flush();
    test_inc_dec();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
